// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder:
// RV32 funct3 size codes, FSM state type and request legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Size/alignment/direction legality; the range check lives in the top
    // because it depends on the instance parameters.
    function automatic logic is_legal(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] addr
    );
        case (funct3)
            F3_B:    is_legal = 1'b1;
            F3_H:    is_legal = ~addr[0];
            F3_W:    is_legal = (addr == 2'b00);
            F3_BU:   is_legal = ~we;
            F3_HU:   is_legal = ~we & ~addr[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: merges store data into the old word and extracts
// the sign/zero-extended load value. Ports: i_old, i_wdata, i_funct3,
// i_lane in; o_store (merged word), o_load (extended value) out.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_store,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_old[7:0];
        case (i_lane)
            2'd1:    w_byte = i_old[15:8];
            2'd2:    w_byte = i_old[23:16];
            2'd3:    w_byte = i_old[31:24];
            default: w_byte = i_old[7:0];
        endcase
        w_half  = i_lane[1] ? i_old[31:16] : i_old[15:0];
        o_load  = 32'h0;
        o_store = i_old;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_load = i_funct3[2] ? {24'h0, w_byte}
                                     : {{24{w_byte[7]}}, w_byte};
                case (i_lane)
                    2'd1:    o_store[15:8]  = i_wdata[7:0];
                    2'd2:    o_store[23:16] = i_wdata[7:0];
                    2'd3:    o_store[31:24] = i_wdata[7:0];
                    default: o_store[7:0]   = i_wdata[7:0];
                endcase
            end
            F3_H, F3_HU: begin
                o_load = i_funct3[2] ? {16'h0, w_half}
                                     : {{16{w_half[15]}}, w_half};
                if (i_lane[1])
                    o_store[31:16] = i_wdata[15:0];
                else
                    o_store[15:0] = i_wdata[15:0];
            end
            F3_W: begin
                o_load  = i_old;
                o_store = i_wdata;
            end
            default: begin
                o_load  = 32'h0;
                o_store = i_old;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts a load/store, waits LATENCY
// edges, commits to a local word array and returns a response.
// Ports: req_* request handshake in, rsp_* response handshake out.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          CW       = $clog2(LATENCY + 1);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);

    dmem_state_t r_state;
    dmem_state_t w_next;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_ok;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic [31:0] w_old;
    logic [31:0] w_store;
    logic [31:0] w_load;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Offset is unsigned, so addresses below BASE_ADDR wrap and fail.
    assign w_off = r_addr - BASE_ADDR;
    assign w_ok  = is_legal(r_we, r_f3, r_addr[1:0]) && (w_off < LIMIT);
    assign w_idx = w_off[AW+1:2];
    assign w_old = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_old    (w_old),
        .i_wdata  (r_wdata),
        .i_funct3 (r_f3),
        .i_lane   (r_addr[1:0]),
        .o_store  (w_store),
        .o_load   (w_load)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                // Commit edge is the last of the LATENCY edges.
                if (r_cnt == '0) begin
                    w_commit = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_f3        <= 3'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_f3    <= req_funct3;
                r_cnt   <= CNT_INIT;
            end else if (r_state == WAIT && !w_commit) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= ~w_ok;
                r_rsp_rdata <= (w_ok && !r_we) ? w_load : 32'h0;
            end else if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    // Array is not reset; an async reset forces IDLE so no commit occurs.
    always_ff @(posedge clk) begin
        if (w_commit && w_ok && r_we)
            r_mem[w_idx] <= w_store;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model,
// directed plus random requests, backpressure and mid-WAIT reset.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;
    int rr_mode = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    logic [7:0] mb [0:DEPTH*4-1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference: memory as a flat byte array, access size in bytes.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         output logic [31:0] rd, output logic er);
        int sz;
        logic ok;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok = (f3 != 3'd3) && (f3 < 3'd6) && !(we && f3[2])
             && ((addr % sz) == 0) && (addr < DEPTH * 4);
        rd = 32'h0;
        er = !ok;
        if (ok) begin
            if (we) begin
                for (int i = 0; i < sz; i++)
                    mb[addr + i] = 8'(wdata >> (8 * i));
            end else begin
                for (int i = 0; i < sz; i++)
                    rd = rd | ({24'h0, mb[addr + i]} << (8 * i));
                if (!f3[2] && sz < 4 && rd[8*sz-1])
                    rd = rd | (32'hFFFF_FFFF << (8 * sz));
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input bit keep);
        exp_t e;
        int w;
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got req_ready 0 want 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        if (keep) begin
            model(we, addr, wdata, f3, e.rdata, e.err);
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sbq.size() != 0 || rsp_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'h0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       rsp_ready = ($urandom_range(0, 2) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    logic seen = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (!seen) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid 1 want 0");
                    cur.rdata = 32'h0;
                    cur.err   = 1'b0;
                    cur.acc   = cyc;
                end else begin
                    cur = sbq.pop_front();
                    chk("latency", 32'(cyc - cur.acc), 32'(LAT));
                end
                seen = 1'b1;
            end
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            if (rsp_ready)
                seen = 1'b0;
        end
    end

    initial begin
        int w;
        logic        rwe;
        logic [31:0] raddr;
        logic [2:0]  rf3;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++)
            issue(1'b1, 32'(i * 4), $urandom, 3'b010, 1'b1);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3'b000, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3'b100, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b001, 1'b1);
        issue(1'b0, 32'h12, 32'h0, 3'b101, 1'b1);
        issue(1'b1, 32'h11, 32'h55, 3'b000, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b1, 32'h12, 32'h1234, 3'b001, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'h12, 32'h0, 3'b010, 1'b1);
        issue(1'b1, 32'h11, 32'hFFFF, 3'b001, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'(DEPTH * 4), 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b011, 1'b1);
        issue(1'b1, 32'h10, 32'h77, 3'b100, 1'b1);
        issue(1'b0, 32'hFFFF_FFFC, 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        drain();

        rr_mode = 1;
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", 32'(rsp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        end
        @(posedge clk);
        #2;
        rr_mode = 2;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_fall", 32'(rsp_valid), 32'h0);
        chk("bp_req_ready_back", 32'(req_ready), 32'h1);
        rr_mode = 0;

        for (int i = 0; i < 300; i++) begin
            rwe = 1'($urandom);
            rf3 = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r == 0)
                raddr = 32'h1000 + 32'($urandom_range(0, 15));
            else if (r == 1)
                raddr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                raddr = 32'($urandom_range(0, 255));
            issue(rwe, raddr, $urandom, rf3, 1'b1);
        end
        drain();

        issue(1'b1, 32'h20, 32'hA5A5_A5A5, 3'b010, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
